// File: rtl/dmac_fifo_reader.sv
// Read-side master for the DMAC data FIFO: pulls a programmed number of words
// via rd_en/rd_ack/rd_err and hands each one to the sink over valid/ready.
//
//   state | meaning
//   IDLE  | waiting for start
//   REQ   | request a word whenever the FIFO is not empty
//   WAIT  | FIFO response cycle (ack, err, or missing response)
//   HOLD  | word presented to sink until m_ready
//   DONE  | one-cycle completion pulse
//   ERR   | sticky error, waits for a new start
module dmac_fifo_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  xfer_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  words_left,
    input  logic                  fifo_empty,
    input  logic                  fifo_rd_ack,
    input  logic                  fifo_rd_err,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  remain_q, remain_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  err_q, err_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            remain_q  <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        err_d      = err_q;
        fifo_rd_en = 1'b0;
        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    err_d    = 1'b0;
                    remain_d = xfer_len;
                    state_d  = (xfer_len != '0) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                fifo_rd_en = ~fifo_empty;
                if (!fifo_empty) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // The FIFO always answers the cycle after rd_en; silence is a fault.
                if (fifo_rd_err) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else if (fifo_rd_ack) begin
                    m_data_d  = fifo_dout;
                    m_valid_d = 1'b1;
                    if (remain_q != '0) begin
                        remain_d = remain_q - CNT_ONE;
                    end
                    state_d = S_HOLD;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = (remain_q == '0) ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                m_valid_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_HOLD);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign words_left = remain_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;

endmodule

// File: tb/tb_dmac_fifo_reader.sv
// Scoreboard bench for dmac_fifo_reader: behavioural FIFO responder, directed
// stimulus pushing expected sink words, and a negedge monitor that checks them.
module tb_dmac_fifo_reader;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] xfer_len = '0;
    logic          busy, done, err;
    logic [CW-1:0] words_left;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_ack = 1'b0;
    logic          fifo_rd_err = 1'b0;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int resp_mode = 0;      // 0 ack, 1 rd_err, 2 no response
    bit inject_late = 1'b0;
    int rd_cnt = 0;
    int done_cnt = 0;

    dmac_fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .xfer_len   (xfer_len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_left (words_left),
        .fifo_empty (fifo_empty),
        .fifo_rd_ack(fifo_rd_ack),
        .fifo_rd_err(fifo_rd_err),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic do_start(input logic [CW-1:0] len);
        start = 1'b1;
        xfer_len = len;
        tick(1);
        start = 1'b0;
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0: return done;
            1: return m_valid;
            default: return err;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string name, input int max, output int n);
        n = 0;
        while (!cond(sel) && n < max) begin
            tick(1);
            n++;
        end
        if (!cond(sel)) check({name, "_timeout"}, cond(sel), 1);
    endtask

    // FIFO responder: answers the cycle after the edge that sampled rd_en
    initial begin
        logic rd_seen;
        forever begin
            @(negedge clk);
            rd_seen = fifo_rd_en;
            @(posedge clk);
            #1;
            fifo_rd_ack = 1'b0;
            fifo_rd_err = 1'b0;
            if (rd_seen && reset_n) begin
                if (resp_mode == 0) begin
                    if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
                    fifo_rd_ack = 1'b1;
                end else if (resp_mode == 1) begin
                    fifo_rd_err = 1'b1;
                end
            end else if (inject_late) begin
                fifo_rd_ack = 1'b1;
                fifo_dout = 32'hDEAD_BEEF;
                inject_late = 1'b0;
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Monitor: sink scoreboard plus HOLD stability and rd_en spacing
    initial begin
        logic          prev_rd = 1'b0;
        logic          prev_hold = 1'b0;
        logic [DW-1:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_rd = 1'b0;
                prev_hold = 1'b0;
            end else begin
                if (fifo_rd_en) begin
                    rd_cnt++;
                    check("rd_en_back_to_back", prev_rd, 0);
                    check("rd_en_while_busy", busy, 1);
                end
                if (done) done_cnt++;
                if (prev_hold) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_data_stable", m_data, prev_data);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) check("m_valid_unexpected", m_valid, 0);
                    else check("m_data", m_data, exp_q.pop_front());
                end
                prev_rd = fifo_rd_en;
                prev_hold = m_valid && !m_ready;
                prev_data = m_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rc, db;
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_words_left", words_left, 0);
        check("rst_m_data", m_data, 0);
        reset_n = 1'b1;
        tick(2);

        // basic transfer
        m_ready = 1'b1;
        push_word(32'hA1); push_word(32'hA2); push_word(32'hA3);
        exp_q.push_back(32'hA1); exp_q.push_back(32'hA2); exp_q.push_back(32'hA3);
        rd_cnt = 0; db = done_cnt;
        do_start(3);
        check("t1_words_left_start", words_left, 3);
        check("t1_busy", busy, 1);
        wait_for(0, "t1_done", 20, n);
        check("t1_latency", n + 1, 10);
        check("t1_words_left_end", words_left, 0);
        check("t1_busy_at_done", busy, 0);
        tick(1);
        check("t1_done_single", done, 0);
        check("t1_done_cnt", done_cnt - db, 1);
        check("t1_rd_cnt", rd_cnt, 3);

        // empty stall
        exp_q.push_back(32'h55); exp_q.push_back(32'h66);
        rd_cnt = 0; db = done_cnt;
        do_start(2);
        tick(5);
        check("t2_no_rd_empty", rd_cnt, 0);
        check("t2_busy_stall", busy, 1);
        check("t2_words_left", words_left, 2);
        push_word(32'h55);
        wait_for(1, "t2_valid", 10, n);
        check("t2_words_left_cap", words_left, 1);
        tick(4);
        check("t2_busy_second", busy, 1);
        check("t2_no_done", done_cnt - db, 0);
        check("t2_rd_cnt1", rd_cnt, 1);
        push_word(32'h66);
        wait_for(0, "t2_done", 10, n);
        check("t2_rd_cnt2", rd_cnt, 2);
        tick(1);

        // sink backpressure and ignored start in HOLD
        m_ready = 1'b0;
        push_word(32'hB1); push_word(32'hB2);
        exp_q.push_back(32'hB1); exp_q.push_back(32'hB2);
        rd_cnt = 0;
        do_start(2);
        wait_for(1, "t3_valid", 10, n);
        rc = rd_cnt;
        check("t3_words_left_cap", words_left, 1);
        tick(2);
        do_start(5);
        check("t3_start_ignored_wl", words_left, 1);
        check("t3_start_ignored_valid", m_valid, 1);
        check("t3_busy_hold", busy, 1);
        tick(1);
        check("t3_no_rd_hold", rd_cnt, rc);
        m_ready = 1'b1;
        wait_for(0, "t3_done", 20, n);
        check("t3_rd_cnt", rd_cnt, 2);
        tick(1);

        // rd_err during WAIT
        resp_mode = 1;
        push_word(32'hC1);
        db = done_cnt;
        do_start(1);
        wait_for(2, "t4_err", 10, n);
        check("t4_busy", busy, 0);
        check("t4_m_valid", m_valid, 0);
        check("t4_rd_en", fifo_rd_en, 0);
        tick(3);
        check("t4_err_sticky", err, 1);
        check("t4_no_done", done_cnt - db, 0);
        resp_mode = 0;
        exp_q.push_back(32'hC1);
        do_start(1);
        check("t4_err_cleared", err, 0);
        check("t4_busy_restart", busy, 1);
        wait_for(0, "t4_done", 20, n);
        tick(1);

        // missing ack
        resp_mode = 2;
        push_word(32'hD1);
        do_start(1);
        wait_for(2, "t4_noack_err", 10, n);
        check("t4_noack_busy", busy, 0);
        fifo_q.delete();
        fifo_empty = 1'b1;
        resp_mode = 0;

        // zero length, from ERR
        rc = rd_cnt;
        do_start(0);
        check("t5_done", done, 1);
        check("t5_err_cleared", err, 0);
        check("t5_busy", busy, 0);
        check("t5_words_left", words_left, 0);
        tick(1);
        check("t5_done_once", done, 0);
        check("t5_no_rd", rd_cnt, rc);

        // reset in WAIT, then a late ack
        push_word(32'hE1);
        do_start(1);
        tick(1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_m_valid", m_valid, 0);
        check("t6_rd_en", fifo_rd_en, 0);
        check("t6_err", err, 0);
        check("t6_words_left", words_left, 0);
        tick(2);
        reset_n = 1'b1;
        inject_late = 1'b1;
        tick(3);
        check("t6_late_ack_valid", m_valid, 0);
        check("t6_late_ack_busy", busy, 0);
        check("t6_late_ack_data", m_data, 0);
        fifo_q.delete();
        fifo_empty = 1'b1;

        tick(2);
        check("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
